cejmu_byte_serializer: RTL and testbench



---
 rtl/cejmu_byte_serializer.sv | 159 +++++++++++++++
 tb/tb_cejmu_byte_serializer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cejmu_byte_serializer.sv
// ----------------------------------------------------------------------------
// cejmu_byte_serializer
//
// Buffers bytes from the project output mux in a small FIFO and shifts each
// byte out MSB-first on a single pin. A frame strobe marks the 8 bit times of
// each byte. Consecutive frames are separated by exactly two low strobe cycles:
// one GAP cycle and one IDLE cycle.
//
// Ports:
//   clk        clock; all logic on the rising edge
//   rst        synchronous active-high reset; clears all state
//   in_data    byte from the project mux
//   in_valid   in_data is valid this cycle
//   in_ready   FIFO can accept a byte; derived from the registered count
//   ser_out    serial data, MSB first (registered)
//   ser_frame  high while a byte's 8 bits are on ser_out (registered)
//   busy       high when the FSM is not idle or the FIFO holds bytes
//   count      FIFO occupancy
// ----------------------------------------------------------------------------
module cejmu_byte_serializer #(
   parameter int unsigned DEPTH = 4,  // FIFO entries; power of two, >= 2
   parameter int unsigned DIV   = 1   // clock cycles each serial bit is held
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         ser_out,
   output logic                         ser_frame,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CW-1:0] CountFull = CW'(DEPTH);
   localparam logic [DW-1:0] DivLast   = DW'(DIV - 1);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StGap
   } state_t;

   state_t          r_state;
   logic [7:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [7:0]      r_shreg;
   logic [2:0]      r_bit_cnt;
   logic [DW-1:0]   r_div_cnt;
   logic            r_ser_out;
   logic            r_ser_frame;

   logic            w_push;
   logic            w_pop;

   // Acceptance depends only on the registered count: a pop on the same edge
   // does not open a slot for a full FIFO (no pass-through).
   assign w_push = in_valid && (r_count != CountFull);
   assign w_pop  = (r_state == StIdle) && (r_count != '0);

   // Storage needs no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Serializer FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_shreg     <= '0;
         r_bit_cnt   <= '0;
         r_div_cnt   <= '0;
         r_ser_out   <= 1'b0;
         r_ser_frame <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_ser_out   <= 1'b0;
               r_ser_frame <= 1'b0;
               if (w_pop) begin
                  // The popped MSB goes straight to the output register so
                  // bit 7 is visible in the first frame cycle.
                  r_shreg     <= r_mem[r_rd_ptr];
                  r_ser_out   <= r_mem[r_rd_ptr][7];
                  r_ser_frame <= 1'b1;
                  r_bit_cnt   <= 3'd7;
                  r_div_cnt   <= '0;
                  r_state     <= StShift;
               end
            end

            StShift: begin
               if (r_div_cnt == DivLast) begin
                  if (r_bit_cnt == 3'd0) begin
                     r_ser_out   <= 1'b0;
                     r_ser_frame <= 1'b0;
                     r_state     <= StGap;
                  end else begin
                     r_shreg   <= {r_shreg[6:0], 1'b0};
                     r_ser_out <= r_shreg[6];
                     r_bit_cnt <= r_bit_cnt - 3'd1;
                     r_div_cnt <= '0;
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + DW'(1);
               end
            end

            StGap: begin
               r_ser_out   <= 1'b0;
               r_ser_frame <= 1'b0;
               r_state     <= StIdle;
            end

            default: begin
               r_ser_out   <= 1'b0;
               r_ser_frame <= 1'b0;
               r_state     <= StIdle;
            end
         endcase
      end
   end

   assign in_ready  = (r_count != CountFull);
   assign ser_out   = r_ser_out;
   assign ser_frame = r_ser_frame;
   assign busy      = (r_state != StIdle) || (r_count != '0);
   assign count     = r_count;

endmodule

// File: tb/tb_cejmu_byte_serializer.sv
// ----------------------------------------------------------------------------
// tb_cejmu_byte_serializer
//
// Directed bench for cejmu_byte_serializer. dut1 uses DIV=1 and dut3 uses
// DIV=3; both have DEPTH=4. A negedge monitor on dut1 rebuilds bytes, frame
// lengths and inter-frame gaps from the serial pins.
// ----------------------------------------------------------------------------
module tb_cejmu_byte_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic [7:0] in_data1  = '0;
   logic       in_valid1 = 1'b0;
   logic       in_ready1;
   logic       ser_out1;
   logic       ser_frame1;
   logic       busy1;
   logic [2:0] count1;

   logic [7:0] in_data3  = '0;
   logic       in_valid3 = 1'b0;
   logic       in_ready3;
   logic       ser_out3;
   logic       ser_frame3;
   logic       busy3;
   logic [2:0] count3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cejmu_byte_serializer #(.DEPTH(4), .DIV(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data1),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .ser_out   (ser_out1),
      .ser_frame (ser_frame1),
      .busy      (busy1),
      .count     (count1)
   );

   cejmu_byte_serializer #(.DEPTH(4), .DIV(3)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .ser_out   (ser_out3),
      .ser_frame (ser_frame3),
      .busy      (busy3),
      .count     (count3)
   );

   // ---------------- serial monitor for dut1 ----------------
   logic       mon_en = 1'b0;
   logic [7:0] byteq[$];
   int         lenq[$];
   int         gapq[$];
   logic       m_prev;
   logic       m_seen;
   logic [7:0] m_byte;
   int         m_hi;
   int         m_lo;

   always @(negedge clk) begin
      if (!mon_en) begin
         byteq.delete();
         lenq.delete();
         gapq.delete();
         m_prev <= 1'b0;
         m_seen <= 1'b0;
         m_byte <= '0;
         m_hi   <= 0;
         m_lo   <= 0;
      end else begin
         if (ser_frame1) begin
            if (!m_prev && m_seen) gapq.push_back(m_lo);
            m_byte <= {m_byte[6:0], ser_out1};
            m_hi   <= m_hi + 1;
         end else begin
            if (m_prev) begin
               byteq.push_back(m_byte);
               lenq.push_back(m_hi);
               m_hi   <= 0;
               m_seen <= 1'b1;
               m_lo   <= 1;
            end else begin
               m_lo <= m_lo + 1;
            end
         end
         m_prev <= ser_frame1;
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] pat;
      logic       pre_ready;
      logic       done;
      logic       seen;
      int         idx;

      // Reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_count", 32'(count1), 0);
      chk("rst_ser_out", 32'(ser_out1), 0);
      chk("rst_frame", 32'(ser_frame1), 0);
      chk("rst_busy", 32'(busy1), 0);
      chk("rst_ready", 32'(in_ready1), 1);
      chk("rst_ready3", 32'(in_ready3), 1);
      chk("rst_busy3", 32'(busy3), 0);

      // 1. DIV=1, single byte 0xA5
      in_data1  = 8'hA5;
      in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      in_data1  = 8'h00;
      chk("t1_count_after_push", 32'(count1), 1);
      chk("t1_frame_pre", 32'(ser_frame1), 0);
      pat = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t1_frame", 32'(ser_frame1), 1);
         chk("t1_bit", 32'(ser_out1), 32'(pat[7-i]));
      end
      tick();
      chk("t1_gap_frame", 32'(ser_frame1), 0);
      chk("t1_gap_busy", 32'(busy1), 1);
      tick();
      chk("t1_idle_frame", 32'(ser_frame1), 0);
      chk("t1_idle_busy", 32'(busy1), 0);

      // 2/3. Continuous offer of 0x01..0x06; full FIFO while FSM pops
      mon_en = 1'b1;
      idx       = 0;
      in_data1  = 8'h01;
      in_valid1 = 1'b1;
      for (int cyc = 0; cyc < 300 && idx < 6; cyc++) begin
         pre_ready = in_ready1;
         tick();
         if (pre_ready) idx++;
         in_data1 = 8'(idx + 1);
         if (idx == 6) in_valid1 = 1'b0;
         chk("t2_count_le4", 32'(count1 <= 3'd4), 1);
         chk("t2_ready_vs_count", 32'(in_ready1), 32'(count1 != 3'd4));
         if (cyc == 4) chk("t2_full", 32'(count1), 4);
         if (cyc == 10) begin
            chk("t3_full_before_pop", 32'(count1), 4);
            chk("t3_idx_before_pop", 32'(idx), 5);
         end
         if (cyc == 11) begin
            chk("t3_count_after_pop", 32'(count1), 3);
            chk("t3_ready_after_pop", 32'(in_ready1), 1);
            chk("t3_not_accepted", 32'(idx), 5);
         end
         if (cyc == 12) begin
            chk("t3_count_after_accept", 32'(count1), 4);
            chk("t3_accepted", 32'(idx), 6);
         end
      end
      in_valid1 = 1'b0;
      done = 1'b0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         tick();
         if (byteq.size() == 6 && !busy1) done = 1'b1;
      end
      chk("t2_drain", 32'(done), 1);
      chk("t2_nbytes", 32'(byteq.size()), 6);
      chk("t2_ngaps", 32'(gapq.size()), 5);
      for (int i = 0; i < byteq.size() && i < 6; i++) begin
         chk("t2_byte", 32'(byteq[i]), 32'(i + 1));
         chk("t2_len", 32'(lenq[i]), 8);
      end
      for (int i = 0; i < gapq.size(); i++) begin
         chk("t2_gap", 32'(gapq[i]), 2);
      end
      mon_en = 1'b0;

      // 4. DIV=3, byte 0x80
      in_data3  = 8'h80;
      in_valid3 = 1'b1;
      tick();
      in_valid3 = 1'b0;
      chk("t4_count", 32'(count3), 1);
      for (int i = 0; i < 24; i++) begin
         tick();
         chk("t4_frame", 32'(ser_frame3), 1);
         chk("t4_bit", 32'(ser_out3), (i < 3) ? 32'd1 : 32'd0);
      end
      tick();
      chk("t4_frame_end", 32'(ser_frame3), 0);

      // 5. Reset during bit 4 of 0xFF with 0x0F queued
      in_data1  = 8'hFF;
      in_valid1 = 1'b1;
      tick();
      in_data1 = 8'h0F;
      tick();
      in_valid1 = 1'b0;
      tick();
      tick();
      tick();
      chk("t5_pre_bit4", 32'(ser_out1), 1);
      chk("t5_pre_frame", 32'(ser_frame1), 1);
      chk("t5_pre_count", 32'(count1), 1);
      rst      = 1'b1;
      in_data1 = 8'hAA;
      tick();
      rst = 1'b0;
      chk("t5_ser_out", 32'(ser_out1), 0);
      chk("t5_frame", 32'(ser_frame1), 0);
      chk("t5_count", 32'(count1), 0);
      chk("t5_busy", 32'(busy1), 0);
      chk("t5_ready", 32'(in_ready1), 1);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (ser_frame1) seen = 1'b1;
      end
      chk("t5_no_frames", 32'(seen), 0);
      chk("t5_busy_quiet", 32'(busy1), 0);
      in_data1  = 8'h3C;
      in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      pat = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t5_new_frame", 32'(ser_frame1), 1);
         chk("t5_new_bit", 32'(ser_out1), 32'(pat[7-i]));
      end
      tick();
      chk("t5_new_end", 32'(ser_frame1), 0);
      tick();

      // 6. Nine bytes 0x10..0x18 paced at one per frame period
      mon_en = 1'b1;
      tick();
      for (int b = 0; b < 9; b++) begin
         chk("t6_ready", 32'(in_ready1), 1);
         in_data1  = 8'(8'h10 + b);
         in_valid1 = 1'b1;
         tick();
         in_valid1 = 1'b0;
         for (int k = 0; k < 9; k++) begin
            tick();
            chk("t6_ready_hold", 32'(in_ready1), 1);
         end
      end
      done = 1'b0;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         tick();
         if (byteq.size() == 9 && !busy1) done = 1'b1;
      end
      chk("t6_drain", 32'(done), 1);
      chk("t6_nbytes", 32'(byteq.size()), 9);
      for (int i = 0; i < byteq.size() && i < 9; i++) begin
         chk("t6_byte", 32'(byteq[i]), 32'(8'h10 + i));
         chk("t6_len", 32'(lenq[i]), 8);
      end
      for (int i = 0; i < gapq.size(); i++) begin
         chk("t6_gap", 32'(gapq[i]), 2);
      end
      mon_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
